// File: rtl/link_bridge.sv
// link_bridge: peripheral endpoint bridging the processor message port to an 8-bit valid/ready peer link.
//   TX: snd/interface_data push 32-bit words into a FIFO; words leave MSB byte first on tx_data/tx_valid/tx_ready.
//   RX: bytes on rx_data/rx_valid/rx_ready are assembled MSB first into words and queued; interrupt_eth flags a
//       non-empty queue, interrupt_source_data shows its head (0 when empty), irq_ack pops it.
//   tx_overflow: sticky, a word was dropped on a full TX FIFO.  tx_busy: TX FIFO non-empty or a word in flight.
//   Optional macro LINK_LOOPBACK_EN adds input loopback, which routes TX bytes into the RX assembler internally.
module link_bridge #(
  parameter int TX_DEPTH = 4,
  parameter int RX_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
`ifdef LINK_LOOPBACK_EN
  input  logic        loopback,
`endif
  input  logic        snd,
  input  logic [31:0] interface_data,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        interrupt_eth,
  output logic [31:0] interrupt_source_data,
  input  logic        irq_ack,
  output logic        tx_overflow,
  output logic        tx_busy
);
  localparam int TAW = $clog2(TX_DEPTH);
  localparam int RAW = $clog2(RX_DEPTH);
  typedef enum logic {TX_IDLE, TX_SEND} tx_state_t;
  typedef enum logic {RX_COLLECT, RX_HOLD} rx_state_t;
  logic [31:0] tx_mem [TX_DEPTH];
  logic [TAW:0] tx_wp, tx_rp;
  logic tx_empty, tx_full, tx_push, tx_pop, tx_xfer, tx_last, tx_vld, tx_rdy;
  tx_state_t tx_state, tx_next;
  logic [31:0] tx_word;
  logic [1:0] tx_cnt;
  logic [31:0] rx_mem [RX_DEPTH];
  logic [RAW:0] rx_wp, rx_rp, rx_wp_n, rx_rp_n;
  logic rx_empty, rx_full, rx_push, rx_pop, rx_xfer, rx_last, rx_vld, rx_rdy, lb;
  logic [7:0] rx_byte;
  rx_state_t rx_state, rx_next;
  logic [31:0] rx_word, rx_head_n;
  logic [1:0] rx_cnt;

`ifdef LINK_LOOPBACK_EN
  assign lb = loopback;
`else
  assign lb = 1'b0;
`endif

  assign tx_vld   = tx_state == TX_SEND;
  assign tx_rdy   = lb ? rx_rdy : tx_ready;
  assign tx_xfer  = tx_vld & tx_rdy;
  assign tx_last  = tx_xfer & (tx_cnt == 2'd3);
  assign tx_valid = tx_vld & ~lb;
  assign tx_data  = tx_word[31:24];
  assign tx_empty = tx_wp == tx_rp;
  assign tx_full  = (tx_wp[TAW] != tx_rp[TAW]) && (tx_wp[TAW-1:0] == tx_rp[TAW-1:0]);
  assign tx_busy  = ~tx_empty | tx_vld;
  // a full FIFO still takes the word when the FSM pops in the same cycle
  assign tx_push  = snd & (~tx_full | tx_pop);

  // load from idle, or right after the 4th byte so consecutive words stream without a gap
  always_comb begin
    tx_pop  = ~tx_empty & (~tx_vld | tx_last);
    tx_next = tx_pop ? TX_SEND : (tx_last ? TX_IDLE : tx_state);
  end

  always_ff @(posedge clk)
    if (tx_push) tx_mem[tx_wp[TAW-1:0]] <= interface_data;

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      tx_state    <= TX_IDLE;
      tx_wp       <= '0;
      tx_rp       <= '0;
      tx_word     <= '0;
      tx_cnt      <= '0;
      tx_overflow <= 1'b0;
    end else begin
      tx_state    <= tx_next;
      tx_wp       <= tx_wp + {{TAW{1'b0}}, tx_push};
      tx_rp       <= tx_rp + {{TAW{1'b0}}, tx_pop};
      tx_overflow <= tx_overflow | (snd & ~tx_push);
      if (tx_pop) begin
        tx_word <= tx_mem[tx_rp[TAW-1:0]];
        tx_cnt  <= '0;
      end else if (tx_xfer) begin
        tx_word <= {tx_word[23:0], 8'h00};
        tx_cnt  <= tx_cnt + 2'd1;
      end
    end

  assign rx_vld   = lb ? tx_vld : rx_valid;
  assign rx_byte  = lb ? tx_word[31:24] : rx_data;
  assign rx_ready = rx_rdy & ~lb;
  assign rx_xfer  = rx_vld & rx_rdy;
  assign rx_last  = rx_xfer & (rx_cnt == 2'd3);
  assign rx_empty = rx_wp == rx_rp;
  assign rx_full  = (rx_wp[RAW] != rx_rp[RAW]) && (rx_wp[RAW-1:0] == rx_rp[RAW-1:0]);
  assign rx_pop   = irq_ack & ~rx_empty;
  assign rx_push  = (rx_state == RX_HOLD) & (~rx_full | rx_pop);
  assign rx_wp_n  = rx_wp + {{RAW{1'b0}}, rx_push};
  assign rx_rp_n  = rx_rp + {{RAW{1'b0}}, rx_pop};
  // head after this edge; bypass the word being written when it lands on the new head slot
  assign rx_head_n = (rx_push && rx_wp[RAW-1:0] == rx_rp_n[RAW-1:0]) ? rx_word : rx_mem[rx_rp_n[RAW-1:0]];

  always_comb rx_next = rx_last ? RX_HOLD : (rx_push ? RX_COLLECT : rx_state);

  always_ff @(posedge clk)
    if (rx_push) rx_mem[rx_wp[RAW-1:0]] <= rx_word;

  // rx_ready is a register tracking the next state so it reads 0 while reset is held
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rx_state              <= RX_COLLECT;
      rx_rdy                <= 1'b0;
      rx_word               <= '0;
      rx_cnt                <= '0;
      rx_wp                 <= '0;
      rx_rp                 <= '0;
      interrupt_eth         <= 1'b0;
      interrupt_source_data <= '0;
    end else begin
      rx_state              <= rx_next;
      rx_rdy                <= rx_next == RX_COLLECT;
      rx_wp                 <= rx_wp_n;
      rx_rp                 <= rx_rp_n;
      interrupt_eth         <= rx_wp_n != rx_rp_n;
      interrupt_source_data <= (rx_wp_n != rx_rp_n) ? rx_head_n : '0;
      if (rx_xfer) begin
        rx_word <= {rx_word[23:0], rx_byte};
        rx_cnt  <= rx_cnt + 2'd1;
      end
    end
endmodule

// File: tb/tb_link_bridge.sv
// tb_link_bridge: self-checking bench for link_bridge (TX table, backpressure, overflow, RX queue, reset mid-word).
module tb_link_bridge;
  logic clk = 0, rst = 1, snd = 0, tx_ready = 0, rx_valid = 0, irq_ack = 0;
  logic [31:0] interface_data = '0;
  logic [7:0] rx_data = '0;
  logic [7:0] tx_data;
  logic tx_valid, rx_ready, interrupt_eth, tx_overflow, tx_busy;
  logic [31:0] interrupt_source_data;
  int total = 0, bad = 0;
  logic [7:0] txq [$];
  logic [31:0] rxq [$];
  typedef struct {logic [31:0] w; logic [3:0][7:0] b;} txv_t;
  txv_t tv [4];

  always #5 clk = ~clk;

  link_bridge dut (
    .clk(clk), .rst(rst), .snd(snd), .interface_data(interface_data),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .interrupt_eth(interrupt_eth), .interrupt_source_data(interrupt_source_data),
    .irq_ack(irq_ack), .tx_overflow(tx_overflow), .tx_busy(tx_busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_word(input logic [31:0] w, input bit keep);
    snd = 1;
    interface_data = w;
    if (keep) for (int k = 0; k < 4; k++) txq.push_back(w[31-8*k -: 8]);
    step();
    snd = 0;
  endtask

  task automatic rx_byte(input logic [7:0] b);
    int n = 0;
    rx_valid = 1;
    rx_data = b;
    while (!rx_ready && n < 50) begin
      step();
      n++;
    end
    if (n == 50) chk("rx_ready_timeout", rx_ready, 1);
    step();
    rx_valid = 0;
  endtask

  task automatic rx_word(input logic [31:0] w);
    for (int k = 0; k < 4; k++) rx_byte(w[31-8*k -: 8]);
    rxq.push_back(w);
  endtask

  // every accepted TX byte is checked against the scoreboard
  always @(negedge clk)
    if (!rst && tx_valid && tx_ready) begin
      if (txq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL tx_extra: got byte %h expected none", tx_data);
      end else chk("tx_byte", {24'h0, tx_data}, {24'h0, txq.pop_front()});
    end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    tv[0] = '{32'hDEADBEEF, {8'hDE, 8'hAD, 8'hBE, 8'hEF}};
    tv[1] = '{32'h11223344, {8'h11, 8'h22, 8'h33, 8'h44}};
    tv[2] = '{32'hA5A50F0F, {8'hA5, 8'hA5, 8'h0F, 8'h0F}};
    tv[3] = '{32'h00000001, {8'h00, 8'h00, 8'h00, 8'h01}};
    step(3);
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_rx_ready", rx_ready, 0);
    chk("rst_eth", interrupt_eth, 0);
    chk("rst_isd", interrupt_source_data, 0);
    chk("rst_ovf", tx_overflow, 0);
    chk("rst_busy", tx_busy, 0);
    rst = 0;
    tx_ready = 1;
    step(2);
    chk("rx_ready_after_rst", rx_ready, 1);

    foreach (tv[i]) begin
      send_word(tv[i].w, 1);
      chk("busy_n1", tx_busy, 1);
      chk("valid_n1", tx_valid, 0);
      step();
      for (int k = 0; k < 4; k++) begin
        chk("seq_valid", tx_valid, 1);
        chk("seq_byte", tx_data, tv[i].b[3-k]);
        step();
      end
      chk("seq_idle", tx_valid, 0);
      chk("seq_busy_end", tx_busy, 0);
    end

    send_word(32'h0BADF00D, 1);
    send_word(32'hFEEDC0DE, 1);
    for (int k = 0; k < 8; k++) begin
      chk("stream_valid", tx_valid, 1);
      step();
    end
    chk("stream_idle", tx_valid, 0);

    send_word(32'h11223344, 1);
    step(3);
    tx_ready = 0;
    for (int k = 0; k < 5; k++) begin
      chk("bp_hold", tx_data, 8'h33);
      chk("bp_valid", tx_valid, 1);
      step();
    end
    tx_ready = 1;
    step();
    chk("bp_last", tx_data, 8'h44);
    step();
    chk("bp_idle", tx_valid, 0);
    chk("bp_q", txq.size(), 0);

    tx_ready = 0;
    for (int i = 1; i <= 6; i++) begin
      send_word(i * 32'h01010101, i <= 5);
      if (i == 5) chk("ovf_before", tx_overflow, 0);
    end
    chk("ovf_set", tx_overflow, 1);
    chk("ovf_inflight", tx_data, 8'h01);
    tx_ready = 1;
    n = 0;
    while (txq.size() > 0 && n < 100) begin
      step();
      n++;
    end
    chk("ovf_drained", txq.size(), 0);
    chk("ovf_busy", tx_busy, 0);
    chk("ovf_sticky", tx_overflow, 1);

    rx_word(32'hCAFEF00D);
    chk("rx_hold_ready", rx_ready, 0);
    chk("rx_eth_m1", interrupt_eth, 0);
    step();
    chk("rx_eth_m2", interrupt_eth, 1);
    chk("rx_head", interrupt_source_data, rxq.pop_front());
    irq_ack = 1;
    step();
    irq_ack = 0;
    chk("ack_eth", interrupt_eth, 0);
    chk("ack_isd", interrupt_source_data, 0);
    irq_ack = 1;
    step();
    irq_ack = 0;
    chk("ack_empty_eth", interrupt_eth, 0);
    chk("ack_empty_isd", interrupt_source_data, 0);
    chk("ack_empty_ready", rx_ready, 1);

    for (int i = 0; i < 5; i++) rx_word(32'h10000000 * (i + 1) + 32'h00ABCDEF);
    chk("full_ready", rx_ready, 0);
    step(3);
    chk("full_ready_held", rx_ready, 0);
    chk("full_eth", interrupt_eth, 1);
    chk("full_head", interrupt_source_data, rxq.pop_front());
    irq_ack = 1;
    step();
    irq_ack = 0;
    chk("full_ready_back", rx_ready, 1);
    n = 0;
    while (interrupt_eth && n < 20) begin
      if (rxq.size() == 0) chk("drain_extra", interrupt_source_data, 0);
      else chk("drain_head", interrupt_source_data, rxq.pop_front());
      irq_ack = 1;
      step();
      irq_ack = 0;
      n++;
    end
    chk("drain_q", rxq.size(), 0);
    chk("drain_isd", interrupt_source_data, 0);

    rx_byte(8'h99);
    rx_byte(8'h88);
    send_word(32'hAABBCCDD, 1);
    step(3);
    rst = 1;
    #1;
    chk("mid_tx_valid", tx_valid, 0);
    chk("mid_tx_data", tx_data, 0);
    chk("mid_rx_ready", rx_ready, 0);
    chk("mid_eth", interrupt_eth, 0);
    chk("mid_isd", interrupt_source_data, 0);
    chk("mid_ovf", tx_overflow, 0);
    chk("mid_busy", tx_busy, 0);
    txq.delete();
    step(2);
    rst = 0;
    rx_word(32'h01020304);
    chk("post_eth_m1", interrupt_eth, 0);
    step();
    chk("post_eth", interrupt_eth, 1);
    chk("post_head", interrupt_source_data, rxq.pop_front());
    irq_ack = 1;
    step();
    irq_ack = 0;
    chk("post_ack", interrupt_eth, 0);
    chk("post_txq", txq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/link_bridge.md
# link_bridge

Peripheral-side endpoint of the processor's external message interface. It captures words the processor emits with `snd`/`interface_data`, buffers them and serialises them MSB-byte-first onto an 8-bit valid/ready link toward the peer board. In the other direction it assembles 4-byte words from the peer link, queues them, raises `interrupt_eth` and presents the queue head on `interrupt_source_data`, which the processor reads through RDI.

## Interface
- `TX_DEPTH`, default 4: TX word FIFO depth; must be a power of two and at least 2.
- `RX_DEPTH`, default 4: RX word FIFO depth; must be a power of two and at least 2.
- `clk` in 1: single clock; everything is synchronous to its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `snd` in 1: one-cycle pulse; push `interface_data` into the TX FIFO.
- `interface_data` in 32: word to transmit; sampled when `snd`=1.
- `tx_data` out 8: outgoing byte.
- `tx_valid` out 1: `tx_data` valid.
- `tx_ready` in 1: peer accepts the byte.
- `rx_data` in 8: incoming byte.
- `rx_valid` in 1: `rx_data` valid.
- `rx_ready` out 1: bridge accepts the byte.
- `interrupt_eth` out 1: RX FIFO non-empty (level).
- `interrupt_source_data` out 32: RX FIFO head word; 0 when the FIFO is empty.
- `irq_ack` in 1: one-cycle pulse from the processor's RTI decode; pops the RX head.
- `tx_overflow` out 1: sticky; a `snd` arrived while the TX FIFO was full.
- `tx_busy` out 1: TX FIFO non-empty or a word is in flight.

## Operation
- **Reset values.** All outputs reset to 0: `tx_data`, `tx_valid`, `rx_ready`, `interrupt_eth`, `interrupt_source_data`, `tx_overflow`, `tx_busy`. Reset also clears both FIFOs, both byte counters and both FSMs.
- **TX FIFO write.** `snd`=1 and FIFO not full writes the word.
- **TX FIFO full.**
  - If a pop happens in the same cycle, the push is accepted.
  - Otherwise the word is dropped and `tx_overflow` is set. Only reset clears it.
- **TX FSM.**
  - States are TX_IDLE and TX_SEND.
  - TX_IDLE → TX_SEND when the FIFO is non-empty. The FSM pops the head into a shift register and sets byte count 0.
  - In TX_SEND, `tx_valid`=1 and `tx_data` = byte[31:24], then [23:16], [15:8], [7:0].
  - A byte advances only on `tx_valid & tx_ready`. `tx_data` is held stable while `tx_ready`=0.
  - After the 4th transfer: if the FIFO is non-empty, the next word loads with no idle cycle; otherwise the FSM returns to TX_IDLE.
- **RX FSM.**
  - States are RX_COLLECT and RX_HOLD.
  - In RX_COLLECT, `rx_ready`=1. Each `rx_valid & rx_ready` shifts the byte in MSB-first and increments the byte count (mod 4).
  - On the 4th byte the FSM enters RX_HOLD with the completed word.
  - In RX_HOLD, `rx_ready`=0. The word is written to the RX FIFO when it is not full, or when `irq_ack` pops in the same cycle, and the FSM returns to RX_COLLECT.
  - RX data is back-pressured and never dropped.
- **RX pop.** `irq_ack` while the RX FIFO is empty is ignored. `interrupt_eth` and `interrupt_source_data` are registered from the FIFO state.
- **Pointers.** log2(depth)+1 bits with wrap bit. Full = low bits equal and wrap bits differ; empty = pointers equal.

## Timing
- **`snd` to first byte.** `snd` at cycle N (FIFO empty, TX_IDLE) gives `tx_valid`=1 with byte[31:24] at N+2.
- **Word duration.** With `tx_ready` tied 1, a word takes 4 cycles and back-to-back words stream with no gaps.
- **RX word latency.** 4th RX byte accepted at cycle M: RX_HOLD at M+1, FIFO write at M+1 (not full), `interrupt_eth`=1 and head visible at M+2.
- **`irq_ack` to next head.** `irq_ack` at cycle K: the next head (or 0 / `interrupt_eth`=0 if empty) appears at K+1.
- **Reset mid-operation.**
  - Reset mid-word discards the partial TX and RX words and drops `tx_valid` immediately (asynchronously).
  - Link peers must restart framing after `rst` deasserts.

## Configuration
- **`LINK_LOOPBACK_EN` defined.**
  - Adds input port `loopback` (1 bit).
  - When `loopback`=1, TX bytes feed the RX assembler internally: the internal handshake uses RX `rx_ready` as the TX ready.
  - While looped back, external `tx_valid` is forced to 0, external `rx_ready` is forced to 0, and `rx_data`/`rx_valid` are ignored.
  - Switching `loopback` is legal only while `tx_busy`=0 and RX is in RX_COLLECT with byte count 0.
- **`LINK_LOOPBACK_EN` undefined.** The port is absent and the path is always external.

## Test plan
- **Single transmit.** `snd` with 0xDEADBEEF, `tx_ready`=1 → bytes DE, AD, BE, EF on 4 consecutive cycles starting 2 cycles after `snd`; `tx_busy` drops after the last byte.
- **Backpressure.** `tx_ready`=0 for 5 cycles mid-word → `tx_data` held stable, no byte lost or repeated; 0x11223344 arrives intact.
- **TX overflow.** TX_DEPTH=4 with `tx_ready`=0 and 6 `snd` pulses (words 1–6) → first word in flight, words 2–5 queued, word 6 dropped, `tx_overflow`=1; with `tx_ready`=1, words 1–5 emerge in order.
- **Receive and ack.** Peer sends 0xCAFEF00D → `interrupt_eth`=1 and `interrupt_source_data`=0xCAFEF00D 2 cycles after the 4th byte; `irq_ack` → both return to 0 next cycle; a second `irq_ack` on empty has no effect.
- **RX full.** RX FIFO full (4 unacked words), a 5th word arrives → `rx_ready`=0 after its 4th byte. `irq_ack` → the held word enters the FIFO the same cycle and `rx_ready` returns to 1 next cycle.
- **Reset mid-word.** `rst` pulsed after 2 RX bytes and 2 TX bytes → all outputs 0. A fresh 4-byte RX word 0x01020304 is then received correctly.
